// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite slave memory with address/data pipeline, byte-lane writes and two-cycle ERROR response.
// Latency: data phase completes WAIT_STATES cycles after the address phase; reads return the full word.
// Backpressure: Hready_out low through wait states and ERR1; address phases are ignored while it is low.
module ahb_lite_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  Hsel,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [2:0]            Hburst,
    input  logic                  Hmastlock,
    input  logic [3:0]            Hprot,
    input  logic [2:0]            Hsize,
    input  logic [1:0]            Htrans,
    input  logic                  Hwrite,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic                  Hready_in,
    output logic                  Hready_out,
    output logic                  Hresp,
    output logic [DATA_WIDTH-1:0] Hrdata
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int IDXW  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            wait_cnt, wait_cnt_nxt;
    logic [ADDR_WIDTH-1:0] dp_addr;
    logic [2:0]            dp_size;
    logic                  dp_write;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic                  addr_err;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [IDXW-1:0]       dp_idx;
    logic [OFFW-1:0]       dp_off;
    logic [BYTES-1:0]      byte_en;
    logic                  unused_ok;

    assign Hready_out = (state != S_WAIT) && (state != S_ERR1);
    assign Hresp      = (state == S_ERR1) || (state == S_ERR2);
    assign accept     = Hsel && Hready_in && Hready_out && Htrans[1];

    assign dp_idx = dp_addr[OFFW +: IDXW];
    assign dp_off = dp_addr[OFFW-1:0];

    // Burst, lock and protection attributes do not affect a flat memory.
    assign unused_ok = ^{Hburst, Hmastlock, Hprot, Htrans[0], dp_addr};

    always_comb begin
        align_mask = (ADDR_WIDTH'(1) << Hsize) - ADDR_WIDTH'(1);
        addr_err   = (Hsize > 3'(OFFW))
                  || ((Haddr & align_mask) != '0)
                  || ({1'b0, Haddr} >= MEM_BYTES);
    end

    // A lane is written when it falls in the same 2**size-byte group as the access offset.
    always_comb begin
        byte_en = '0;
        for (int b = 0; b < BYTES; b++) begin
            byte_en[b] = ((b >> dp_size) == (int'(dp_off) >> dp_size));
        end
    end

    always_comb begin
        Hrdata = '0;
        if (state == S_DATA && !dp_write) begin
            Hrdata = mem[dp_idx];
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_nxt = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = 4'(WAIT_STATES);
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    state_nxt = S_DATA;
                end
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            dp_addr  <= '0;
            dp_size  <= '0;
            dp_write <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                dp_addr  <= Haddr;
                dp_size  <= Hsize;
                dp_write <= Hwrite;
            end
            // Commit at the edge closing the data phase, so a following read sees it.
            if (state == S_DATA && dp_write) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (byte_en[b]) begin
                        mem[dp_idx][8*b +: 8] <= Hwdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Directed bench: three slave instances (0, 3 and 4 wait states) share the master signals, selected one at a time.
module tb_ahb_lite_slave_mem;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    logic        sel0, sel3, sel4;
    logic        rdy0, rdy3, rdy4;
    logic        resp0, resp3, resp4;
    logic [31:0] rd0, rd3, rd4;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    ahb_lite_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hreset(hreset), .Hsel(sel0), .Haddr(haddr), .Hburst(3'b000),
        .Hmastlock(1'b0), .Hprot(4'b0011), .Hsize(hsize), .Htrans(htrans), .Hwrite(hwrite),
        .Hwdata(hwdata), .Hready_in(rdy0), .Hready_out(rdy0), .Hresp(resp0), .Hrdata(rd0)
    );

    ahb_lite_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .hclk(hclk), .hreset(hreset), .Hsel(sel3), .Haddr(haddr), .Hburst(3'b000),
        .Hmastlock(1'b0), .Hprot(4'b0011), .Hsize(hsize), .Htrans(htrans), .Hwrite(hwrite),
        .Hwdata(hwdata), .Hready_in(rdy3), .Hready_out(rdy3), .Hresp(resp3), .Hrdata(rd3)
    );

    ahb_lite_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(4)) u_ws4 (
        .hclk(hclk), .hreset(hreset), .Hsel(sel4), .Haddr(haddr), .Hburst(3'b000),
        .Hmastlock(1'b0), .Hprot(4'b0011), .Hsize(hsize), .Htrans(htrans), .Hwrite(hwrite),
        .Hwdata(hwdata), .Hready_in(rdy4), .Hready_out(rdy4), .Hresp(resp4), .Hrdata(rd4)
    );

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge hclk);
    endtask

    task automatic addr_phase(input logic [1:0] tr, input logic wr, input logic [31:0] a, input logic [2:0] sz);
        htrans = tr;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
    endtask

    initial begin
        hreset = 1'b1;
        sel0 = 1'b0; sel3 = 1'b0; sel4 = 1'b0;
        hwdata = '0;
        addr_phase(2'd0, 1'b0, 32'h0, 3'd0);
        repeat (2) @(posedge hclk);
        step();
        hreset = 1'b0;
        check_bit("reset_ready", rdy0, 1'b1);
        check_bit("reset_resp", resp0, 1'b0);
        check_word("reset_rdata", rd0, 32'h0);
        check_bit("reset_ready_ws4", rdy4, 1'b1);

        // Write 0x10 then read it back, zero wait states
        sel0 = 1'b1;
        addr_phase(2'd2, 1'b1, 32'h10, 3'd2);
        step();
        check_bit("wr_data_ready", rdy0, 1'b1);
        check_bit("wr_data_resp", resp0, 1'b0);
        hwdata = 32'hDEADBEEF;
        addr_phase(2'd2, 1'b0, 32'h10, 3'd2);
        step();
        check_word("raw_rdata", rd0, 32'hDEADBEEF);
        check_bit("raw_ready", rdy0, 1'b1);
        check_bit("raw_resp", resp0, 1'b0);

        // Byte lane write into word 0x20
        addr_phase(2'd2, 1'b1, 32'h20, 3'd2);
        step();
        hwdata = 32'h11223344;
        addr_phase(2'd2, 1'b1, 32'h22, 3'd0);
        step();
        hwdata = 32'h00AA0000;
        addr_phase(2'd2, 1'b0, 32'h20, 3'd2);
        step();
        check_word("byte_lane_rdata", rd0, 32'h11AA3344);

        // Unaligned word write -> two-cycle ERROR, memory untouched
        addr_phase(2'd2, 1'b1, 32'h21, 3'd2);
        step();
        check_bit("unal_err1_ready", rdy0, 1'b0);
        check_bit("unal_err1_resp", resp0, 1'b1);
        check_word("unal_err1_rdata", rd0, 32'h0);
        htrans = 2'd0;
        hwdata = 32'hFFFFFFFF;
        step();
        check_bit("unal_err2_ready", rdy0, 1'b1);
        check_bit("unal_err2_resp", resp0, 1'b1);
        addr_phase(2'd2, 1'b0, 32'h20, 3'd2);
        step();
        check_word("unal_mem_kept", rd0, 32'h11AA3344);
        check_bit("unal_after_resp", resp0, 1'b0);

        // Out-of-range read, recovery via read presented during ERR2
        addr_phase(2'd2, 1'b0, 32'h400, 3'd2);
        step();
        check_bit("oor_err1_ready", rdy0, 1'b0);
        check_bit("oor_err1_resp", resp0, 1'b1);
        htrans = 2'd0;
        step();
        check_bit("oor_err2_ready", rdy0, 1'b1);
        check_bit("oor_err2_resp", resp0, 1'b1);
        addr_phase(2'd2, 1'b0, 32'h10, 3'd2);
        step();
        check_word("oor_recover_rdata", rd0, 32'hDEADBEEF);
        check_bit("oor_recover_resp", resp0, 1'b0);
        check_bit("oor_recover_ready", rdy0, 1'b1);

        // Oversized transfer is an error
        addr_phase(2'd2, 1'b0, 32'h10, 3'd3);
        step();
        check_bit("size_err1_ready", rdy0, 1'b0);
        check_bit("size_err1_resp", resp0, 1'b1);
        htrans = 2'd0;
        step();
        step();
        check_bit("size_idle_resp", resp0, 1'b0);
        check_word("size_idle_rdata", rd0, 32'h0);

        // BUSY and deselected transfers do not access memory
        addr_phase(2'd1, 1'b0, 32'h10, 3'd2);
        step();
        check_word("busy_rdata", rd0, 32'h0);
        check_bit("busy_ready", rdy0, 1'b1);
        sel0 = 1'b0;
        addr_phase(2'd2, 1'b0, 32'h10, 3'd2);
        step();
        check_word("nosel_rdata", rd0, 32'h0);

        // Last valid word is in range
        sel0 = 1'b1;
        addr_phase(2'd2, 1'b0, 32'h3FC, 3'd2);
        step();
        check_bit("last_word_resp", resp0, 1'b0);
        check_bit("last_word_ready", rdy0, 1'b1);
        htrans = 2'd0;
        sel0 = 1'b0;
        step();

        // Three wait states: write 0x10, then read it while wiggling the address bus
        sel3 = 1'b1;
        addr_phase(2'd2, 1'b1, 32'h10, 3'd2);
        step();
        for (int i = 0; i < 3; i++) begin
            hwdata = 32'hCAFEF00D;
            htrans = 2'd0;
            check_bit("ws3_wr_wait_ready", rdy3, 1'b0);
            step();
        end
        check_bit("ws3_wr_data_ready", rdy3, 1'b1);
        addr_phase(2'd2, 1'b0, 32'h10, 3'd2);
        step();
        for (int i = 0; i < 3; i++) begin
            check_bit("ws3_rd_wait_ready", rdy3, 1'b0);
            check_word("ws3_rd_wait_rdata", rd3, 32'h0);
            addr_phase(2'd2, 1'b1, 32'h44 + 32'(i * 4), 3'd2);
            step();
        end
        check_bit("ws3_rd_data_ready", rdy3, 1'b1);
        check_bit("ws3_rd_data_resp", resp3, 1'b0);
        check_word("ws3_rd_data_rdata", rd3, 32'hCAFEF00D);
        htrans = 2'd0;
        step();
        check_word("ws3_after_rdata", rd3, 32'h0);
        check_bit("ws3_after_ready", rdy3, 1'b1);
        sel3 = 1'b0;

        // Four wait states: reset during the second wait cycle aborts the write
        sel4 = 1'b1;
        hwdata = 32'h12345678;
        addr_phase(2'd2, 1'b1, 32'h30, 3'd2);
        step();
        check_bit("ws4_wait1_ready", rdy4, 1'b0);
        htrans = 2'd0;
        step();
        check_bit("ws4_wait2_ready", rdy4, 1'b0);
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        check_bit("ws4_reset_ready", rdy4, 1'b1);
        check_bit("ws4_reset_resp", resp4, 1'b0);
        check_word("ws4_reset_rdata", rd4, 32'h0);
        addr_phase(2'd2, 1'b0, 32'h30, 3'd2);
        step();
        for (int i = 0; i < 4; i++) begin
            check_bit("ws4_rd_wait_ready", rdy4, 1'b0);
            htrans = 2'd0;
            step();
        end
        check_bit("ws4_rd_data_ready", rdy4, 1'b1);
        check_bit("ws4_rd_data_resp", resp4, 1'b0);
        check_word("ws4_rd_data_rdata", rd4, 32'h0);
        sel4 = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
